// File: rtl/piso_tx.sv
`timescale 1ns/1ps
`default_nettype none
// piso_tx: framed serial transmitter (start, WIDTH data bits LSB first, stop), DIV clocks per bit.
// Optional even-parity bit between data and stop when PISO_TX_PARITY_EN is defined.
module piso_tx #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             CLK,
  input  logic             NRST,
  input  logic [WIDTH-1:0] D,
  input  logic             LOAD,
  output logic             Q,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CW = 8;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef PISO_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n, cnt_inc;
  logic [BW-1:0]    bit_idx, bit_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic             cnt_last, bit_last;
  logic             q_n, busy_n, done_n;
`ifdef PISO_TX_PARITY_EN
  logic             parity, parity_n;
`endif

  assign cnt_inc  = cnt + CW'(1);
  assign cnt_last = (cnt == CW'(DIV - 1));
  assign bit_last = (bit_idx == BW'(WIDTH - 1));

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bit_n    = bit_idx;
    shreg_n  = shreg;
    done_n   = 1'b0;
`ifdef PISO_TX_PARITY_EN
    parity_n = parity;
`endif
    case (state)
      IDLE: begin
        if (LOAD) begin
          state_n  = START;
          cnt_n    = '0;
          bit_n    = '0;
          shreg_n  = D;
`ifdef PISO_TX_PARITY_EN
          parity_n = ^D;
`endif
        end
      end
      START: begin
        if (cnt_last) begin
          cnt_n   = '0;
          state_n = DATA;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      DATA: begin
        if (cnt_last) begin
          cnt_n   = '0;
          shreg_n = shreg >> 1;
          if (bit_last) begin
            bit_n = '0;
`ifdef PISO_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            bit_n = bit_idx + BW'(1);
          end
        end else begin
          cnt_n = cnt_inc;
        end
      end
`ifdef PISO_TX_PARITY_EN
      PARITY: begin
        if (cnt_last) begin
          cnt_n   = '0;
          state_n = STOP;
        end else begin
          cnt_n = cnt_inc;
        end
      end
`endif
      STOP: begin
        if (cnt_last) begin
          cnt_n   = '0;
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      default: state_n = IDLE;
    endcase

    // Outputs are decoded from the next state so the registered line lines up with the state.
    q_n    = 1'b1;
    busy_n = 1'b1;
    case (state_n)
      IDLE:    busy_n = 1'b0;
      START:   q_n    = 1'b0;
      DATA:    q_n    = shreg_n[0];
`ifdef PISO_TX_PARITY_EN
      PARITY:  q_n    = parity_n;
`endif
      default: q_n    = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      Q       <= 1'b1;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shreg   <= shreg_n;
      Q       <= q_n;
      BUSY    <= busy_n;
      DONE    <= done_n;
`ifdef PISO_TX_PARITY_EN
      parity  <= parity_n;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_piso_tx.sv
`timescale 1ns/1ps
`default_nettype none
// tb_piso_tx: directed checks of piso_tx at WIDTH=8/DIV=4 and WIDTH=1/DIV=1.
module tb_piso_tx;

`ifdef PISO_TX_PARITY_EN
  localparam int NB  = 11;
  localparam int NB1 = 4;
`else
  localparam int NB  = 10;
  localparam int NB1 = 3;
`endif

  logic       clk = 1'b0;
  logic       nrst;
  logic [7:0] d;
  logic       load;
  logic       q, busy, done;
  logic [0:0] d1;
  logic       load1;
  logic       q1, busy1, done1;
  int         total = 0;
  int         passes = 0;

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(8), .DIV(4)) u0 (
    .CLK(clk), .NRST(nrst), .D(d), .LOAD(load), .Q(q), .BUSY(busy), .DONE(done)
  );

  piso_tx #(.WIDTH(1), .DIV(1)) u1 (
    .CLK(clk), .NRST(nrst), .D(d1), .LOAD(load1), .Q(q1), .BUSY(busy1), .DONE(done1)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Serial bit k of a WIDTH=8 frame carrying word w.
  function automatic logic exp_bit(input logic [7:0] w, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return w[k-1];
`ifdef PISO_TX_PARITY_EN
    if (k == 9) return ^w;
`endif
    return 1'b1;
  endfunction

  // Entered in the cycle after the accepting edge; leaves in the DONE cycle.
  // poke >= 0 drives D=FF with a one-cycle LOAD pulse at that frame cycle.
  task automatic frame_check(input logic [7:0] w, input int poke, input string tag);
    for (int c = 0; c < NB * 4; c++) begin
      if (poke >= 0 && c == poke) begin
        d    = 8'hFF;
        load = 1'b1;
      end else if (poke >= 0 && c == poke + 1) begin
        load = 1'b0;
      end
      check($sformatf("%s q c%0d", tag, c), q, exp_bit(w, c / 4));
      check($sformatf("%s busy c%0d", tag, c), busy, 1'b1);
      check($sformatf("%s done c%0d", tag, c), done, 1'b0);
      tick();
    end
    check($sformatf("%s done end", tag), done, 1'b1);
    check($sformatf("%s busy end", tag), busy, 1'b0);
    check($sformatf("%s q end", tag), q, 1'b1);
  endtask

  initial begin
    nrst  = 1'b0;
    d     = 8'h00;
    load  = 1'b0;
    d1    = 1'b0;
    load1 = 1'b0;
    tick();
    tick();
    check("rst q", q, 1'b1);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst q1", q1, 1'b1);
    check("rst busy1", busy1, 1'b0);
    nrst = 1'b1;
    tick();
    check("idle q", q, 1'b1);

    // Single frame of A5
    d    = 8'hA5;
    load = 1'b1;
    tick();
    load = 1'b0;
    d    = 8'h5A;
    frame_check(8'hA5, -1, "a5");
    tick();
    check("a5 done pulse", done, 1'b0);
    check("a5 idle busy", busy, 1'b0);

    // Back-to-back frames with LOAD held high
    d    = 8'h3C;
    load = 1'b1;
    tick();
    d = 8'hC3;
    frame_check(8'h3C, -1, "b2b1");
    tick();
    frame_check(8'hC3, -1, "b2b2");
    load = 1'b0;
    tick();
    check("b2b idle busy", busy, 1'b0);
    check("b2b idle done", done, 1'b0);

    // Mid-frame LOAD and D change are ignored
    d    = 8'h00;
    load = 1'b1;
    tick();
    load = 1'b0;
    frame_check(8'h00, 13, "nochg");
    d = 8'h00;
    tick();
    check("nochg no 2nd busy", busy, 1'b0);
    check("nochg no 2nd q", q, 1'b1);
    tick();
    check("nochg still idle", busy, 1'b0);

    // Reset during data bit 3
    d    = 8'hA5;
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int c = 0; c < 17; c++) tick();
    check("abort pre q", q, 1'b0);
    check("abort pre busy", busy, 1'b1);
    #2 nrst = 1'b0;
    #1;
    check("abort async q", q, 1'b1);
    check("abort async busy", busy, 1'b0);
    check("abort async done", done, 1'b0);
    tick();
    check("abort hold done", done, 1'b0);
    tick();
    nrst = 1'b1;
    d    = 8'h07;
    load = 1'b1;
    tick();
    load = 1'b0;
    frame_check(8'h07, -1, "post");
    tick();
    check("post idle", busy, 1'b0);

    // WIDTH=1, DIV=1
    for (int v = 1; v >= 0; v--) begin
      d1    = 1'(v);
      load1 = 1'b1;
      tick();
      load1 = 1'b0;
      for (int c = 0; c < NB1; c++) begin
        check($sformatf("w1 d%0d q c%0d", v, c), q1,
              (c == 0) ? 1'b0 : (c == NB1 - 1) ? 1'b1 : 1'(v));
        check($sformatf("w1 d%0d busy c%0d", v, c), busy1, 1'b1);
        check($sformatf("w1 d%0d done c%0d", v, c), done1, 1'b0);
        tick();
      end
      check($sformatf("w1 d%0d done", v), done1, 1'b1);
      check($sformatf("w1 d%0d busy end", v), busy1, 1'b0);
      tick();
      check($sformatf("w1 d%0d done off", v), done1, 1'b0);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data bits per frame, legal range 1..16.
REQ-002 SHALL have parameter DIV, default 4: clock cycles per serial bit, legal range 1..255.
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port NRST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port D  input  WIDTH  parallel word to transmit.
REQ-006 SHALL have port LOAD  input  1  request to start a frame with the current D.
REQ-007 SHALL have port Q  output  1  serial line, idle-high.
REQ-008 SHALL have port BUSY  output  1  frame in progress; LOAD ignored while high.
REQ-009 SHALL have port DONE  output  1  one-cycle pulse at frame completion.

Function
REQ-010 SHALL implement an FSM with states IDLE, START, DATA, STOP (plus PARITY per REQ-026).
REQ-011 SHALL, in IDLE, drive Q=1, BUSY=0.
REQ-012 SHALL, at a rising edge in IDLE with LOAD=1, capture D into an internal shift register, move to START and clear the bit-cycle counter.
REQ-013 SHALL make D a don't-care at every edge except the accepting edge.
REQ-014 SHALL make BUSY=1 and Q=0 in the cycle after the accepting edge.
REQ-015 SHALL hold each serial bit on Q for exactly DIV cycles, counted by a bit-cycle counter that wraps 0..DIV-1.
REQ-016 SHALL, in DATA, transmit the captured word LSB first, WIDTH bits, using a bit index counter 0..WIDTH-1.
REQ-017 SHALL, in STOP, drive Q=1 for DIV cycles.
REQ-018 SHALL, at the end of STOP, return to IDLE with BUSY=0 and DONE=1 for exactly one cycle.
REQ-019 SHALL produce a frame length from accepting edge to DONE of (WIDTH+2)*DIV cycles (parity disabled).
REQ-020 SHALL ignore LOAD while BUSY=1; the captured word SHALL NOT change mid-frame.
REQ-021 SHALL accept LOAD in the DONE cycle, so back-to-back frames have zero idle bit-times and the next start bit follows immediately.
REQ-022 SHALL, with DIV=1, drive one bit per cycle with no extra idle cycle between states.
REQ-023 SHALL register Q, BUSY and DONE, with no combinational path from LOAD or D to any output.

Reset
REQ-024 SHALL, while NRST=0, force the following immediately and independently of CLK: Q=1, BUSY=0, DONE=0, state IDLE, counters 0, shift register 0.
REQ-025 SHALL abort a frame if reset is asserted mid-frame, produce no DONE, and accept LOAD at the first rising edge after NRST deasserts.

Configuration
REQ-026 SHALL, with macro PISO_TX_PARITY_EN defined, insert state PARITY between DATA and STOP that drives the even-parity bit (XOR of the captured WIDTH bits) for DIV cycles, giving frame length (WIDTH+3)*DIV.
REQ-027 SHALL, without PISO_TX_PARITY_EN, contain no PARITY state or parity logic; behaviour per REQ-019.

Verification
REQ-028 SHALL check: WIDTH=8, DIV=4, D=8'hA5, LOAD pulse → Q = 0,1,0,1,0,0,1,0,1,1, each bit for 4 cycles; DONE 40 cycles after the accepting edge; BUSY high for those 40 cycles.
REQ-029 SHALL check: LOAD held high continuously with D=8'h3C then 8'hC3 → two adjacent frames; second start bit in the cycle after the first DONE; no idle-high gap.
REQ-030 SHALL check: LOAD pulsed and D changed to 8'hFF mid-frame of 8'h00 → frame still transmits 8'h00; no second frame starts.
REQ-031 SHALL check: NRST asserted during data bit 3 → Q=1, BUSY=0 asynchronously; no DONE; new LOAD after release sends a full frame.
REQ-032 SHALL check: with PISO_TX_PARITY_EN, D=8'hA5 → parity bit 0 before stop, DONE at 44 cycles; D=8'h07 → parity bit 1.
REQ-033 SHALL check: DIV=1, WIDTH=1, D=1 → Q = 0,1,1 on consecutive cycles; DONE on cycle 3.
